// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// FSM state encoding and datapath mux/ALU control codes.
package mips_pkg;

  // Opcodes decoded by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  // Coarse ALU request from the FSM, refined by the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. The controller uses the master view, the
// datapath (instruction register, ALU flags, memory) the slave view.
interface multicycle_controller_if #(
  parameter int ALU_CTRL_W = 3
);
  logic [5:0]            op;
  logic [5:0]            funct;
  logic                  zero;
  logic                  mem_ready;
  logic                  iord;
  logic                  mem_write;
  logic                  ir_write;
  logic                  pc_en;
  logic                  reg_dst;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic                  alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            pc_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  instr_done;
  logic                  illegal_op;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_control, instr_done, illegal_op
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, alu_control, instr_done, illegal_op
  );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU decoder: turns the FSM's coarse ALU request plus the R-type funct
// field into the 3-bit ALU operation code.
module mc_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] i_funct,
  input  alu_op_e    i_alu_op,
  output logic [2:0] o_alu_ctrl
);

  // Unknown funct codes and the unused alu_op value fall back to add
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_SUB:  o_alu_ctrl = ALU_SUB;
          FN_AND:  o_alu_ctrl = ALU_AND;
          FN_OR:   o_alu_ctrl = ALU_OR;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          default: o_alu_ctrl = ALU_ADD;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM. Sequences each instruction through fetch,
// decode, execute and writeback states and drives the datapath mux selects
// and write enables. Supports lw/sw/R-type/beq/bne/addi/j, flags illegal
// opcodes and stalls on memory ready.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int MEM_WAIT   = 1,
  parameter int EN_BNE     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);

  state_e     r_state;
  state_e     w_next;
  logic       r_is_bne;

  logic       w_ready;
  logic       w_taken;
  logic       w_iord;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  src_b_e     w_alu_src_b;
  pc_src_e    w_pc_src;
  alu_op_e    w_alu_op;
  logic [2:0] w_alu_ctrl;
  logic       w_done;
  logic       w_illegal;

  // With MEM_WAIT=0 the memory is assumed single-cycle and mem_ready is ignored
  assign w_ready = (MEM_WAIT == 0) ? 1'b1 : bus.mem_ready;
  assign w_taken = r_is_bne ? ~bus.zero : bus.zero;

  // State register; undefined encodings are caught by the next-state default
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Remember whether the decoded branch is bne, for the BRANCH cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_is_bne <= 1'b0;
    else if (r_state == S_DECODE)  r_is_bne <= (bus.op == OP_BNE);
  end

  // Next-state and Moore output decode
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    w_next       = S_FETCH;
    w_iord       = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_FOUR;
    w_pc_src     = PCSRC_ALU;
    w_alu_op     = ALUOP_ADD;
    w_done       = 1'b0;
    w_illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_ir_write = w_ready;
        w_pc_write = w_ready;
        w_next     = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes PC+4 + (SignImm<<2) as the branch target
        w_alu_src_b = SRCB_IMM_SH2;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          OP_BNE: begin
            if (EN_BNE != 0) begin
              w_next = S_BRANCH;
            end else begin
              w_illegal = 1'b1;
              w_done    = 1'b1;
            end
          end
          default: begin
            w_illegal = 1'b1;
            w_done    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = w_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_done       = 1'b1;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        w_done      = w_ready;
        w_next      = w_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_REG;
        w_alu_op    = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_done      = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_REG;
        w_alu_op    = ALUOP_SUB;
        w_pc_src    = PCSRC_ALUOUT;
        w_branch    = 1'b1;
        w_done      = 1'b1;
      end
      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
      end
      S_JUMP: begin
        w_pc_src   = PCSRC_JUMP;
        w_pc_write = 1'b1;
        w_done     = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .i_funct    (bus.funct),
    .i_alu_op   (w_alu_op),
    .o_alu_ctrl (w_alu_ctrl)
  );

  // Enables are gated by rst_n so nothing writes while reset is held; the
  // selects already show FETCH values because the state resets there.
  assign bus.iord        = w_iord;
  assign bus.mem_write   = w_mem_write & rst_n;
  assign bus.ir_write    = w_ir_write & rst_n;
  assign bus.pc_en       = (w_pc_write | (w_branch & w_taken)) & rst_n;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.reg_write   = w_reg_write & rst_n;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.pc_src      = w_pc_src;
  assign bus.alu_control = ALU_CTRL_W'(w_alu_ctrl);
  assign bus.instr_done  = w_done & rst_n;
  assign bus.illegal_op  = w_illegal & rst_n;

endmodule
